// File: rtl/regfile_hilo_pkg.sv
// Shared constants for the GPR/HI-LO register file slice.
package regfile_hilo_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegNum     = 32;

  localparam logic [RegBus-1:0]     ZeroWord    = '0;
  localparam logic                  RstEnable   = 1'b1;
  localparam logic                  WriteEnable = 1'b1;
  localparam logic                  ReadEnable  = 1'b1;
  localparam logic [RegAddrBus-1:0] NOPRegAddr  = '0;

endpackage

// File: rtl/regfile_init_seq.sv
// Post-reset clear sequencer: walks addresses 1..NUM_REGS-1 so the RAM-mapped
// GPR array starts out zeroed, holding busy high until the walk finishes.
module regfile_init_seq
  import regfile_hilo_pkg::*;
#(
  parameter int unsigned ADDR_W   = RegAddrBus,
  parameter int unsigned NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic StInit  = 1'b0;
  localparam logic StReady = 1'b1;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

  logic              state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == LastAddr) begin
        state_d = StReady;
      end
    end
  end

  // r0 is hard-wired to zero on read, so the sweep starts at address 1.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= StInit;
      cnt_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (rst == RstEnable) || (state_q == StInit);
  assign clr_en   = (rst != RstEnable) && (state_q == StInit);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/regfile_hilo.sv
// Architectural state: 32x32 GPR file with two bypassed read ports, plus the
// HI/LO pair. The GPR array is cleared by regfile_init_seq after reset.
module regfile_hilo
  import regfile_hilo_pkg::*;
#(
  parameter int unsigned DATA_W   = RegBus,
  parameter int unsigned ADDR_W   = RegAddrBus,
  parameter int unsigned NUM_REGS = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              whilo_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy_o
);

  logic              busy;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;

  regfile_init_seq #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_init_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign busy_o = busy;

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              gpr_wr;

  // busy covers rst, so pipeline writes are only accepted once READY.
  assign gpr_wr = !busy && (we == WriteEnable) && (waddr != '0);

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (clr_en) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr;
    end else if (gpr_wr) begin
      mem_we    = 1'b1;
      mem_waddr = waddr;
      mem_wdata = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(
    input logic              blocked,
    input logic              re,
    input logic [ADDR_W-1:0] raddr,
    input logic              wr_en,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] stored
  );
    if (blocked || (re != ReadEnable) || (raddr == '0)) begin
      return '0;
    end else if (wr_en && (wr_addr == raddr)) begin
      return wr_data;
    end
    return stored;
  endfunction

  always_comb begin
    rdata1 = read_port(busy, re1, raddr1, we, waddr, wdata, mem[raddr1]);
    rdata2 = read_port(busy, re2, raddr2, we, waddr, wdata, mem[raddr2]);
  end

  logic [DATA_W-1:0] hi_q, lo_q;
  logic              hilo_wr;

  assign hilo_wr = whilo_i && !busy;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (hilo_wr) begin
      hi_q <= hi_i;
      lo_q <= lo_i;
    end
  end

  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (rst == RstEnable) begin
      hi_o = '0;
      lo_o = '0;
    end else if (hilo_wr) begin
      hi_o = hi_i;
      lo_o = lo_i;
    end
  end

endmodule

// File: tb/tb_regfile_hilo.sv
// Directed bench for regfile_hilo: reset sweep, bypass, r0, read enables,
// HI/LO and reset during the clear sweep.
module tb_regfile_hilo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        whilo_i = 1'b0;
  logic [31:0] hi_i = '0;
  logic [31:0] lo_i = '0;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_hilo dut (
    .clk     (clk),
    .rst     (rst),
    .re1     (re1),
    .raddr1  (raddr1),
    .rdata1  (rdata1),
    .re2     (re2),
    .raddr2  (raddr2),
    .rdata2  (rdata2),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .whilo_i (whilo_i),
    .hi_i    (hi_i),
    .lo_i    (lo_i),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .busy_o  (busy_o)
  );

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; whilo_i = 1'b0; re1 = 1'b0; re2 = 1'b0;
  endtask

  // Counts cycles with busy_o high from now on, bounded at 40.
  task automatic count_busy(output int n);
    n = 0;
    #1;
    while (busy_o === 1'b1 && n < 40) begin
      n++;
      tick();
      #1;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; re1 = 1'b1; raddr1 = 5'd1; re2 = 1'b1; raddr2 = 5'd2;
    tick(); #1;
    vectors++;
    if (busy_o !== 1'b1 || rdata1 !== 32'h0 || rdata2 !== 32'h0 ||
        hi_o !== 32'h0 || lo_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b rd1=%h rd2=%h hi=%h lo=%h, want 1/0/0/0/0",
               busy_o, rdata1, rdata2, hi_o, lo_o);
    end
    tick();
    rst = 1'b0; idle_inputs();
    count_busy(n);
    vectors++;
    if (n != 31) begin
      miscompares++;
      $display("FAIL reset_busy_len: got %0d cycles, want 31", n);
    end
    for (int a = 1; a < 32; a++) begin
      re1 = 1'b1; raddr1 = 5'(a); re2 = 1'b1; raddr2 = 5'(32 - a);
      #1;
      vectors++;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_clear r%0d: rd1=%h rd2=%h, want 0", a, rdata1, rdata2);
      end
    end
    vectors++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_hilo: hi=%h lo=%h, want 0", hi_o, lo_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; re1 = 1'b1; raddr1 = 5'd5;
    #1;
    vectors++;
    if (rdata1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: got %h, want deadbeef", rdata1);
    end
    tick();
    we = 1'b0; wdata = 32'h0;
    #1;
    vectors++;
    if (rdata1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL bypass_array: got %h, want deadbeef", rdata1);
    end
    // Both ports bypass the same in-flight write.
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0077;
    re1 = 1'b1; raddr1 = 5'd9; re2 = 1'b1; raddr2 = 5'd9;
    #1;
    vectors++;
    if (rdata1 !== 32'h77 || rdata2 !== 32'h77) begin
      miscompares++;
      $display("FAIL dual_bypass: rd1=%h rd2=%h, want 77", rdata1, rdata2);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_r0();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b1; raddr2 = 5'd0;
    #1;
    vectors++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      miscompares++;
      $display("FAIL r0_bypass: rd1=%h rd2=%h, want 0", rdata1, rdata2);
    end
    tick();
    we = 1'b0;
    #1;
    vectors++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      miscompares++;
      $display("FAIL r0_array: rd1=%h rd2=%h, want 0", rdata1, rdata2);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_read_enable();
    we = 1'b1; waddr = 5'd7; wdata = 32'h1234;
    tick();
    we = 1'b0; re1 = 1'b0; raddr1 = 5'd7; re2 = 1'b0; raddr2 = 5'd7;
    #1;
    vectors++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      miscompares++;
      $display("FAIL re_off: rd1=%h rd2=%h, want 0", rdata1, rdata2);
    end
    re1 = 1'b1; re2 = 1'b1;
    #1;
    vectors++;
    if (rdata1 !== 32'h1234 || rdata2 !== 32'h1234) begin
      miscompares++;
      $display("FAIL re_on: rd1=%h rd2=%h, want 1234", rdata1, rdata2);
    end
    raddr2 = 5'd5;
    #1;
    vectors++;
    if (rdata1 !== 32'h1234 || rdata2 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL re_split: rd1=%h rd2=%h, want 1234/deadbeef", rdata1, rdata2);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_hilo();
    whilo_i = 1'b1; hi_i = 32'hA; lo_i = 32'hB;
    #1;
    vectors++;
    if (hi_o !== 32'hA || lo_o !== 32'hB) begin
      miscompares++;
      $display("FAIL hilo_bypass: hi=%h lo=%h, want a/b", hi_o, lo_o);
    end
    tick();
    whilo_i = 1'b0; hi_i = 32'h5555; lo_i = 32'h6666;
    #1;
    vectors++;
    if (hi_o !== 32'hA || lo_o !== 32'hB) begin
      miscompares++;
      $display("FAIL hilo_hold: hi=%h lo=%h, want a/b", hi_o, lo_o);
    end
    tick();
  endtask

  task automatic test_mid_sweep_reset();
    int n;
    we = 1'b1; waddr = 5'd3; wdata = 32'h55;
    tick();
    we = 1'b0; re1 = 1'b1; raddr1 = 5'd3;
    #1;
    vectors++;
    if (rdata1 !== 32'h55) begin
      miscompares++;
      $display("FAIL sweep_pre_r3: got %h, want 55", rdata1);
    end
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    // Sweep cycle i has the counter at i+1; r2 is already cleared by cycle 5.
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        we = 1'b1; waddr = 5'd2; wdata = 32'hABC;
        re1 = 1'b1; raddr1 = 5'd2;
        whilo_i = 1'b1; hi_i = 32'hC; lo_i = 32'hD;
        #1;
        vectors++;
        if (busy_o !== 1'b1 || rdata1 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
          miscompares++;
          $display("FAIL sweep_blocked: busy=%b rd1=%h hi=%h lo=%h, want 1/0/0/0",
                   busy_o, rdata1, hi_o, lo_o);
        end
      end
      tick();
      idle_inputs();
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL sweep_rst_busy: got %b, want 1", busy_o);
    end
    tick();
    rst = 1'b0;
    count_busy(n);
    vectors++;
    if (n != 31) begin
      miscompares++;
      $display("FAIL sweep_rerun_len: got %0d cycles, want 31", n);
    end
    re1 = 1'b1; raddr1 = 5'd3; re2 = 1'b1; raddr2 = 5'd2;
    #1;
    vectors++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      miscompares++;
      $display("FAIL sweep_cleared: r3=%h r2=%h, want 0", rdata1, rdata2);
    end
    raddr1 = 5'd7; raddr2 = 5'd5;
    #1;
    vectors++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      miscompares++;
      $display("FAIL sweep_all_zero: r7=%h r5=%h hi=%h lo=%h, want 0",
               rdata1, rdata2, hi_o, lo_o);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_r0();
    test_read_enable();
    test_hilo();
    test_mid_sweep_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
